// File: rtl/block_word_bridge.sv
// ---------------------------------------------------------------------------
// block_word_bridge
//
// Purpose:
//   Splits one 256-bit block transfer (8 words of 32 bits, 32-byte aligned)
//   into eight sequential 32-bit word transfers towards a word memory.
//   A block read gathers the eight returned words into blk_read_data.
//   A block write scatters the captured payload word by word.
//   Each word completes on a cycle where word_ready is high.
//   blk_valid pulses for one cycle when the whole block is finished.
//
// Ports:
//   CLK              in   1    sole clock, rising edge
//   RESET            in   1    asynchronous, active-low reset
//   blk_read         in   1    block read request, held until blk_valid
//   blk_write        in   1    block write request, held until blk_valid
//   blk_address      in   32   block byte address, bits [4:0] ignored
//   blk_write_data   in   256  block write payload, word i = [32i+31:32i]
//   blk_read_data    out  256  assembled block read result
//   blk_valid        out  1    one-cycle completion pulse
//   word_address     out  32   word byte address
//   word_read        out  1    word read request
//   word_write       out  1    word write request
//   word_write_data  out  32   word write payload
//   word_write_size  out  2    always 2'b00 (4 bytes)
//   word_read_data   in   32   word read result
//   word_ready       in   1    word memory accepts/completes this cycle
// ---------------------------------------------------------------------------
module block_word_bridge (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         blk_read,
    input  logic         blk_write,
    input  logic [31:0]  blk_address,
    input  logic [255:0] blk_write_data,
    output logic [255:0] blk_read_data,
    output logic         blk_valid,
    output logic [31:0]  word_address,
    output logic         word_read,
    output logic         word_write,
    output logic [31:0]  word_write_data,
    output logic [1:0]   word_write_size,
    input  logic [31:0]  word_read_data,
    input  logic         word_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    // Only the block-aligned upper address bits are kept; the word offset
    // is rebuilt from the index, so base + 4*i is a plain concatenation.
    logic [26:0]   base_q, base_d;
    logic [255:0]  wdata_q, wdata_d;
    logic [255:0]  rdata_q, rdata_d;

    // The byte offset inside a block carries no meaning here.
    logic          unused_addr_low;
    assign unused_addr_low = ^blk_address[4:0];

    assign word_write_size = 2'b00;
    assign blk_read_data   = rdata_q;

    // Next-state and output logic. Word outputs are driven only while a
    // transfer is active; every other state presents all-zero requests.
    // A write request wins over a simultaneous read request, and the read
    // is only picked up again once the requester re-presents it in IDLE.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        base_d          = base_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        word_read       = 1'b0;
        word_write      = 1'b0;
        word_address    = 32'd0;
        word_write_data = 32'd0;
        blk_valid       = 1'b0;

        case (state_q)
            IDLE: begin
                if (blk_write) begin
                    state_d = WRITE;
                    base_d  = blk_address[31:5];
                    wdata_d = blk_write_data;
                    idx_d   = 3'd0;
                end else if (blk_read) begin
                    state_d = READ;
                    base_d  = blk_address[31:5];
                    idx_d   = 3'd0;
                end
            end

            READ: begin
                word_read    = 1'b1;
                word_address = {base_q, idx_q, 2'b00};
                if (word_ready) begin
                    rdata_d[{idx_q, 5'b00000} +: 32] = word_read_data;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE: begin
                word_write      = 1'b1;
                word_address    = {base_q, idx_q, 2'b00};
                word_write_data = wdata_q[{idx_q, 5'b00000} +: 32];
                if (word_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                blk_valid = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset also clears the partially assembled read data
    // so an aborted read never leaks stale words.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            base_q  <= 27'd0;
            wdata_q <= 256'd0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_block_word_bridge.sv
// ---------------------------------------------------------------------------
// tb_block_word_bridge
//
// Directed bench for block_word_bridge: block reads, a stalled block write,
// simultaneous read/write requests, result hold and reset abort.
// ---------------------------------------------------------------------------
module tb_block_word_bridge;

    logic         CLK;
    logic         RESET;
    logic         blk_read;
    logic         blk_write;
    logic [31:0]  blk_address;
    logic [255:0] blk_write_data;
    logic [255:0] blk_read_data;
    logic         blk_valid;
    logic [31:0]  word_address;
    logic         word_read;
    logic         word_write;
    logic [31:0]  word_write_data;
    logic [1:0]   word_write_size;
    logic [31:0]  word_read_data;
    logic         word_ready;

    int compared = 0;
    int mismatched = 0;

    block_word_bridge dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .blk_read        (blk_read),
        .blk_write       (blk_write),
        .blk_address     (blk_address),
        .blk_write_data  (blk_write_data),
        .blk_read_data   (blk_read_data),
        .blk_valid       (blk_valid),
        .word_address    (word_address),
        .word_read       (word_read),
        .word_write      (word_write),
        .word_write_data (word_write_data),
        .word_write_size (word_write_size),
        .word_read_data  (word_read_data),
        .word_ready      (word_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] makeRamp(input logic [31:0] first);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = first + 32'(i);
        end
        return r;
    endfunction

    // Runs one block operation starting in an IDLE cycle (cycle 1) and
    // returns at the negedge of the IDLE cycle that follows DONE.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [255:0] wdata,
                                 input bit stall, input logic [31:0] rdBase,
                                 input int expCycle, input logic [31:0] expBase,
                                 input bit keepRead);
        int cyc;
        int k;
        bit done;
        blk_read       = rd;
        blk_write      = wr;
        blk_address    = addr;
        blk_write_data = wdata;
        word_ready     = 1'b1;
        word_read_data = 32'd0;
        cyc  = 1;
        k    = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            if (cyc == 3) begin
                blk_address    = ~addr;
                blk_write_data = ~wdata;
            end
            if (blk_valid) begin
                checkOutput("validCycle", 256'(cyc), 256'(expCycle));
                checkOutput("wordCount", 256'(k), 256'd8);
                checkOutput("doneWordRead", 256'(word_read), 256'd0);
                checkOutput("doneWordWrite", 256'(word_write), 256'd0);
                checkOutput("doneWordAddr", 256'(word_address), 256'd0);
                checkOutput("doneWordData", 256'(word_write_data), 256'd0);
                blk_write  = 1'b0;
                if (!keepRead) blk_read = 1'b0;
                word_ready = 1'b1;
                done = 1'b1;
            end else begin
                word_ready     = stall ? (cyc % 2 == 1) : 1'b1;
                word_read_data = rdBase + 32'(k);
                checkOutput("wordRead", 256'(word_read), 256'(!wr));
                checkOutput("wordWrite", 256'(word_write), 256'(wr));
                checkOutput("wordAddr", 256'(word_address), 256'(expBase + 32'(4 * k)));
                checkOutput("wordSize", 256'(word_write_size), 256'd0);
                if (wr) begin
                    checkOutput("wordData", 256'(word_write_data),
                                256'(wdata[32 * (k % 8) +: 32]));
                end
                if (word_ready) k++;
            end
        end
        checkOutput("completed", 256'(done), 256'd1);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("validPulse", 256'(blk_valid), 256'd0);
    endtask

    logic [255:0] writeData;
    int guard;

    initial begin
        RESET          = 1'b0;
        blk_read       = 1'b0;
        blk_write      = 1'b0;
        blk_address    = 32'd0;
        blk_write_data = '0;
        word_read_data = 32'd0;
        word_ready     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            writeData[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
        end

        repeat (2) @(negedge CLK);
        checkOutput("rstValid", 256'(blk_valid), 256'd0);
        checkOutput("rstWordRead", 256'(word_read), 256'd0);
        checkOutput("rstWordWrite", 256'(word_write), 256'd0);
        checkOutput("rstWordAddr", 256'(word_address), 256'd0);
        checkOutput("rstReadData", blk_read_data, 256'd0);
        RESET = 1'b1;
        @(negedge CLK);

        $display("[TB] block read at 0x1234");
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0, 32'hA0, 10, 32'h1220, 1'b0);
        checkOutput("readData", blk_read_data, makeRamp(32'hA0));

        $display("[TB] stalled block write at 0x40");
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, writeData, 1'b1, 32'hEE, 18, 32'h40, 1'b0);
        checkOutput("holdAfterWrite", blk_read_data, makeRamp(32'hA0));

        $display("[TB] simultaneous read and write, read held");
        applyStimulus(1'b1, 1'b1, 32'h0000_0080, ~writeData, 1'b0, 32'hEE, 10, 32'h80, 1'b1);
        checkOutput("holdAfterBoth", blk_read_data, makeRamp(32'hA0));
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 32'hB0, 10, 32'h80, 1'b0);
        checkOutput("heldReadData", blk_read_data, makeRamp(32'hB0));

        $display("[TB] reset during block read");
        blk_read    = 1'b1;
        blk_address = 32'h0000_2000;
        word_ready  = 1'b1;
        guard = 0;
        while (!(word_read && word_address == 32'h0000_200C) && guard < 20) begin
            @(posedge CLK);
            @(negedge CLK);
            guard++;
            word_read_data = 32'hC0 + ((word_address - 32'h2000) >> 2);
        end
        checkOutput("reachedWord3", 256'(guard < 20), 256'd1);
        checkOutput("partialData", 256'(blk_read_data[95:0]),
                    256'({32'hC2, 32'hC1, 32'hC0}));
        RESET    = 1'b0;
        blk_read = 1'b0;
        #1;
        checkOutput("abortValid", 256'(blk_valid), 256'd0);
        checkOutput("abortWordRead", 256'(word_read), 256'd0);
        checkOutput("abortWordAddr", 256'(word_address), 256'd0);
        checkOutput("abortReadData", blk_read_data, 256'd0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput("idleValid", 256'(blk_valid), 256'd0);
            checkOutput("idleWordReq", 256'({word_read, word_write}), 256'd0);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/block_word_bridge.md
BLOCK_WORD_BRIDGE -- requirements
Module: block_word_bridge

Interface
REQ-001 Parameters: none; the block size is fixed at 8 words of 32 bits (256 bits, 32-byte aligned).
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 blk_read  input  1  block read request; held high by the requester until blk_valid.
REQ-005 blk_write  input  1  block write request; held high by the requester until blk_valid.
REQ-006 blk_address  input  32  block byte address; bits [4:0] ignored.
REQ-007 blk_write_data  input  256  block write payload; word i = bits [32i+31:32i].
REQ-008 blk_read_data  output  256  assembled block read result; word i = bits [32i+31:32i].
REQ-009 blk_valid  output  1  one-cycle pulse: the current block operation is complete.
REQ-010 word_address  output  32  word byte address to the word memory.
REQ-011 word_read  output  1  word read request.
REQ-012 word_write  output  1  word write request.
REQ-013 word_write_data  output  32  word write payload.
REQ-014 word_write_size  output  2  constant 2'b00 (4 bytes).
REQ-015 word_read_data  input  32  word read result; valid in any cycle where word_ready=1 and word_read=1.
REQ-016 word_ready  input  1  the word memory accepts or completes the presented word this cycle.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-018 IDLE: blk_write=1 -> WRITE; otherwise blk_read=1 -> READ; otherwise stay in IDLE.
REQ-019 If both requests are high, the request SHALL be serviced as a write only; a read requires a fresh request after blk_valid.
REQ-020 On leaving IDLE, the block SHALL capture base={blk_address[31:5],5'b0} and, for writes, blk_write_data.
REQ-021 On leaving IDLE, the block SHALL clear the 3-bit word index i to 0.
REQ-022 Captured values SHALL be used for the whole operation; later input changes SHALL be ignored.
REQ-023 In READ/WRITE: word_address=base+4*i, recomputed every cycle.
REQ-024 In READ: word_read=1, word_write=0.
REQ-025 In WRITE: word_write=1, word_read=0, word_write_data=captured word i.
REQ-026 Outside READ/WRITE: word_read=0, word_write=0, word_address=0, word_write_data=0.
REQ-027 Each word_ready=1 cycle in READ SHALL store word_read_data into blk_read_data slot i.
REQ-028 Each word_ready=1 cycle in READ/WRITE SHALL increment i.
REQ-029 word_ready=0 SHALL hold i, the outputs and the state unchanged, with no timeout.
REQ-030 The word_ready=1 cycle with i=7 SHALL move the FSM to DONE; i SHALL wrap to 0 (don't care).
REQ-031 DONE SHALL last exactly one cycle with blk_valid=1, then return to IDLE unconditionally.
REQ-032 blk_valid SHALL be 0 in every state except DONE.
REQ-033 The minimum latency is 10 cycles from the request edge to blk_valid (1 IDLE + 8 words + 1 DONE), plus 1 per word_ready=0 cycle.
REQ-034 A request still high in the IDLE cycle after DONE SHALL start a new operation.
REQ-035 blk_read_data SHALL be written only in READ; after a read it SHALL hold stable through DONE until the next read overwrites slot 0.
REQ-036 Write operations SHALL leave blk_read_data unchanged.
REQ-037 word_ready in IDLE/DONE SHALL be ignored.

Reset
REQ-038 RESET=0 SHALL immediately and asynchronously force: state IDLE, i=0, blk_valid=0, word_read=0, word_write=0, word_address=0, word_write_data=0, blk_read_data=0, captured base/data=0.
REQ-039 RESET asserted mid-operation SHALL abort it: no blk_valid, no further word requests, and partially assembled read data discarded (zeroed).
REQ-040 After RESET deasserts, the first rising edge SHALL evaluate IDLE transitions normally.

Verification
REQ-041 Read: blk_read=1, blk_address=0x0000_1234, word_ready=1 constantly, word_read_data=0xA0+i -> word_address 0x1220..0x123C, blk_valid on cycle 10, blk_read_data words 0xA0..0xA7.
REQ-042 Write with stalls: blk_write=1, address 0x40, data words 0x11111111*(i+1), word_ready low on every other cycle -> 8 writes of the correct data in order, blk_valid at cycle 18, word_write_size=0.
REQ-043 Simultaneous: blk_read=blk_write=1 -> only word_write asserted, one blk_valid; then a held blk_read starts a READ in the following IDLE cycle.
REQ-044 Reset mid-read: RESET=0 after 3 words accepted -> outputs zero immediately; after release with no request, the FSM stays in IDLE and blk_valid never pulses.
REQ-045 Hold: after a read completes, apply a write with different data -> blk_read_data unchanged; blk_valid high exactly one cycle per operation.
